// File: rtl/alu_exec_unit.sv
// Integer execute stage: one S1 compute register feeding a result FIFO that requests the CDB.
// Optional macro ALU_OVF_TRAP_EN adds signed-overflow exception flags for ADD/SUB.
module alu_exec_unit #(
  parameter int         RESBUF_DEPTH = 4,
  parameter logic [4:0] NONE         = 5'b11111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [5:0]  alu_opcode,
  input  logic [31:0] alu_op1,
  input  logic [31:0] alu_op2,
  input  logic [4:0]  alu_dest_tag,
  output logic        alu_ready,
  output logic        res_valid,
  output logic [4:0]  res_tag,
  output logic [31:0] res_data,
  output logic        res_exc,
  input  logic        res_grant,
  output logic        busy
);

  localparam int PW = $clog2(RESBUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [5:0] {
    F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07,
    F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23,
    F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27,
    F_SLT  = 6'h2A, F_SLTU = 6'h2B
  } funct_e;

  logic        s1_valid;
  logic [5:0]  s1_opcode;
  logic [31:0] s1_op1, s1_op2;
  logic [4:0]  s1_tag;

  logic [31:0] sum, diff, alu_data;

  logic [4:0]    tag_mem  [RESBUF_DEPTH];
  logic [31:0]   data_mem [RESBUF_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   credit;
  logic          head_valid, full, push, pop;
  logic [4:0]    head_tag;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sum      = s1_op1 + s1_op2;
    diff     = s1_op1 - s1_op2;
    alu_data = '0;
    case (s1_opcode)
      F_ADD, F_ADDU: alu_data = sum;
      F_SUB, F_SUBU: alu_data = diff;
      F_AND:         alu_data = s1_op1 & s1_op2;
      F_OR:          alu_data = s1_op1 | s1_op2;
      F_XOR:         alu_data = s1_op1 ^ s1_op2;
      F_NOR:         alu_data = ~(s1_op1 | s1_op2);
      F_SLT:         alu_data = {31'b0, $signed(s1_op1) < $signed(s1_op2)};
      F_SLTU:        alu_data = {31'b0, s1_op1 < s1_op2};
      F_SLLV:        alu_data = s1_op2 << s1_op1[4:0];
      F_SRLV:        alu_data = s1_op2 >> s1_op1[4:0];
      F_SRAV:        alu_data = $signed(s1_op2) >>> s1_op1[4:0];
      default:       alu_data = '0;
    endcase
  end

`ifdef ALU_OVF_TRAP_EN
  logic s1_exc;
  logic exc_mem [RESBUF_DEPTH];

  always_comb begin
    s1_exc = 1'b0;
    if (s1_opcode == F_ADD)
      s1_exc = (s1_op1[31] == s1_op2[31]) && (sum[31] != s1_op1[31]);
    else if (s1_opcode == F_SUB)
      s1_exc = (s1_op1[31] != s1_op2[31]) && (diff[31] != s1_op1[31]);
  end

  always_ff @(posedge clk) begin
    if (push) exc_mem[wr_ptr] <= s1_exc;
  end

  assign res_exc = head_valid & exc_mem[rd_ptr];
`else
  assign res_exc = 1'b0;
`endif

  assign head_valid = (count != '0);
  assign full       = (count == CW'(RESBUF_DEPTH));
  assign head_tag   = tag_mem[rd_ptr];
  assign res_valid  = head_valid && (head_tag != NONE);
  // Null-tag entries never reach the CDB; they retire at the head without a grant.
  assign pop        = head_valid && (res_grant || (head_tag == NONE));
  assign push       = s1_valid && (!full || pop);

  assign res_tag  = head_valid ? head_tag : NONE;
  assign res_data = head_valid ? data_mem[rd_ptr] : '0;
  assign busy     = s1_valid | head_valid;

  // Counts the op the RS may already be registering, so a slot exists when it lands.
  assign credit    = {1'b0, count} + (CW+1)'(s1_valid) + (CW+1)'(alu_valid);
  assign alu_ready = credit < (CW+1)'(RESBUF_DEPTH);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      s1_valid <= alu_valid;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload registers and FIFO storage are not reset; valid bits and count qualify every read.
  always_ff @(posedge clk) begin
    if (alu_valid) begin
      s1_opcode <= alu_opcode;
      s1_op1    <= alu_op1;
      s1_op2    <= alu_op2;
      s1_tag    <= alu_dest_tag;
    end
    if (push) begin
      tag_mem[wr_ptr]  <= s1_tag;
      data_mem[wr_ptr] <= alu_data;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(s1_valid && full && !pop));

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table plus hand sequences, results checked via a scoreboard queue.
// Honours ALU_OVF_TRAP_EN to choose the expected exception flag.
module tb_alu_exec_unit;

  localparam logic [4:0] NONE = 5'b11111;
`ifdef ALU_OVF_TRAP_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [5:0]  alu_opcode = '0;
  logic [31:0] alu_op1 = '0, alu_op2 = '0;
  logic [4:0]  alu_dest_tag = '0;
  logic        alu_ready, res_valid, res_exc, busy;
  logic [4:0]  res_tag;
  logic [31:0] res_data;
  logic        res_grant = 1'b0;

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_opcode(alu_opcode),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_dest_tag(alu_dest_tag),
    .alu_ready(alu_ready), .res_valid(res_valid), .res_tag(res_tag),
    .res_data(res_data), .res_exc(res_exc), .res_grant(res_grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] data;
    logic        exc;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        x;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[20];
  int   checks = 0;
  int   errors = 0;
  logic ready_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ready as seen by the RS at the previous edge; dispatch is legal only when it was 1.
  always @(posedge clk) begin
    if (!rst && alu_valid) check("protocol_ready", {31'b0, ready_prev}, 32'd1);
    ready_prev <= rst ? 1'b1 : alu_ready;
  end

  always @(negedge clk) begin
    if (!rst && res_valid && res_grant) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_tag", {27'b0, res_tag}, {27'b0, mon_e.tag});
        check("sb_data", res_data, mon_e.data);
        check("sb_exc", {31'b0, res_exc}, {31'b0, mon_e.exc});
      end
    end
  end

  task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] d, input logic x);
    int waited = 0;
    while (!ready_prev) begin
      if (waited == 50) begin
        check("ready_timeout", 32'd0, 32'd1);
        return;
      end
      res_grant = 1'b1;
      tick();
      waited++;
    end
    alu_valid = 1'b1; alu_opcode = op; alu_op1 = a; alu_op2 = b; alu_dest_tag = tag;
    if (tag != NONE) exp_q.push_back('{tag, d, x});
    tick();
    alu_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    res_grant = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 40) begin
      tick();
      n++;
    end
    check("drain_done", {31'b0, (exp_q.size() == 0) && !busy}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{6'h20, 32'd5,          32'd7,          32'd12,         1'b0};
    vecs[1]  = '{6'h21, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    vecs[2]  = '{6'h22, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};
    vecs[3]  = '{6'h23, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
    vecs[4]  = '{6'h24, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0};
    vecs[5]  = '{6'h25, 32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF,  1'b0};
    vecs[6]  = '{6'h26, 32'h0000_00FF,  32'h0000_00F0,  32'h0000_000F,  1'b0};
    vecs[7]  = '{6'h27, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0};
    vecs[8]  = '{6'h2A, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
    vecs[9]  = '{6'h2B, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    vecs[10] = '{6'h2A, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[11] = '{6'h04, 32'd4,          32'd1,          32'h0000_0010,  1'b0};
    vecs[12] = '{6'h04, 32'd36,         32'd1,          32'h0000_0010,  1'b0};
    vecs[13] = '{6'h06, 32'd4,          32'h8000_0000,  32'h0800_0000,  1'b0};
    vecs[14] = '{6'h07, 32'd4,          32'h8000_0000,  32'hF800_0000,  1'b0};
    vecs[15] = '{6'h3F, 32'd9,          32'd9,          32'd0,          1'b0};
    vecs[16] = '{6'h20, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  OVF};
    vecs[17] = '{6'h21, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0};
    vecs[18] = '{6'h22, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  OVF};
    vecs[19] = '{6'h23, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0};

    // Reset then idle
    tick(); tick();
    @(negedge clk);
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_res_tag", {27'b0, res_tag}, 32'h1F);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_exc", {31'b0, res_exc}, 32'd0);
    check("rst_alu_ready", {31'b0, alu_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single ADD latency with grant held
    res_grant = 1'b1;
    send(6'h20, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0);
    @(negedge clk);
    check("lat_s1_not_valid", {31'b0, res_valid}, 32'd0);
    check("lat_s1_busy", {31'b0, busy}, 32'd1);
    tick();
    @(negedge clk);
    check("lat_res_valid", {31'b0, res_valid}, 32'd1);
    check("lat_res_tag", {27'b0, res_tag}, 32'd3);
    tick();
    @(negedge clk);
    check("lat_popped_busy", {31'b0, busy}, 32'd0);
    check("lat_popped_valid", {31'b0, res_valid}, 32'd0);

    // Back-to-back fill with no grant
    res_grant = 1'b0;
    tick();
    for (int t = 1; t <= 3; t++) send(6'h21, 32'(t), 32'd0, 5'(t), 32'(t), 1'b0);
    alu_valid = 1'b1; alu_opcode = 6'h21; alu_op1 = 32'd4; alu_op2 = 32'd0; alu_dest_tag = 5'd4;
    exp_q.push_back('{5'd4, 32'd4, 1'b0});
    @(negedge clk);
    check("credit_ready_drop", {31'b0, alu_ready}, 32'd0);
    tick();
    alu_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("full_ready_low", {31'b0, alu_ready}, 32'd0);
    check("full_head_valid", {31'b0, res_valid}, 32'd1);
    check("full_head_tag", {27'b0, res_tag}, 32'd1);
    drain();

    // Vector table, grant held high
    for (int i = 0; i < 20; i++)
      send(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i), vecs[i].d, vecs[i].x);
    drain();

    // Null-tag entry retires without a grant and is never broadcast
    res_grant = 1'b0;
    send(6'h20, 32'd1, 32'd1, NONE, 32'd2, 1'b0);
    @(negedge clk);
    check("none_s1_busy", {31'b0, busy}, 32'd1);
    tick();
    @(negedge clk);
    check("none_masked", {31'b0, res_valid}, 32'd0);
    check("none_queued_busy", {31'b0, busy}, 32'd1);
    check("none_tag", {27'b0, res_tag}, 32'h1F);
    tick();
    @(negedge clk);
    check("none_dropped", {31'b0, busy}, 32'd0);

    // Three entries queued, then push and pop on the same edge
    tick();
    for (int t = 10; t <= 12; t++) send(6'h20, 32'(t), 32'd0, 5'(t), 32'(t), 1'b0);
    tick(); tick();
    @(negedge clk);
    check("three_ready", {31'b0, alu_ready}, 32'd1);
    send(6'h20, 32'd13, 32'd0, 5'd13, 32'd13, 1'b0);
    res_grant = 1'b1;
    tick();
    res_grant = 1'b0;
    @(negedge clk);
    check("pushpop_head_tag", {27'b0, res_tag}, 32'd11);
    check("pushpop_count3_ready", {31'b0, alu_ready}, 32'd1);

    // Ten ops with a bursty grant to wrap the pointers
    for (int i = 0; i < 10; i++) begin
      res_grant = (i % 3) != 0;
      send(6'h21, 32'(i), 32'd100, 5'(20 + i), 32'(i) + 32'd100, 1'b0);
    end
    drain();

    // Reset with two entries queued discards them
    res_grant = 1'b0;
    send(6'h26, 32'd1, 32'd2, 5'd5, 32'd3, 1'b0);
    send(6'h26, 32'd4, 32'd2, 5'd6, 32'd6, 1'b0);
    tick(); tick();
    @(negedge clk);
    check("pre_rst_valid", {31'b0, res_valid}, 32'd1);
    rst = 1'b1;
    tick();
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_valid", {31'b0, res_valid}, 32'd0);
    check("mid_rst_tag", {27'b0, res_tag}, 32'h1F);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_ready", {31'b0, alu_ready}, 32'd1);
    rst = 1'b0;
    res_grant = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("post_rst_no_stale", {31'b0, res_valid}, 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
